// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the instruction-fetch pipeline front end.
//   DATA_W             : datapath / address width
//   RESET_PC_DEFAULT   : PC loaded by reset unless overridden
//   NOP_INSTR_DEFAULT  : instruction word used as an IF/ID bubble
//   PC_STEP            : sequential fetch increment (bytes)
//   fetch_state_e      : fetch-stage FSM encoding
// ----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [DATA_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [DATA_W-1:0] PC_STEP           = 32'd4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_adder.sv
// ----------------------------------------------------------------------------
// pc_adder
// Sequential-PC incrementer: pc_plus4 = pc_in + 4, modulo 2^32 (no carry out).
//   pc_in    in  32  current PC
//   pc_plus4 out 32  PC of the next sequential instruction
// ----------------------------------------------------------------------------
module pc_adder
    import pipeline_pkg::*;
(
    input  logic [DATA_W-1:0] pc_in,
    output logic [DATA_W-1:0] pc_plus4
);

    assign pc_plus4 = pc_in + PC_STEP;

endmodule

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
// Instruction fetch stage: drives a non-cancellable instruction-memory request
// at the current PC and fills the IF/ID pipeline register, honouring decode
// stalls and branch redirects.
//   clk, reset            clock and synchronous active-high reset
//   branch_taken/_target  redirect request and address
//   stall                 hold IF/ID (decode hazard)
//   imem_req/_addr        memory request and address
//   imem_ack/_rdata       memory response
//   pc                    current fetch PC
//   if_id_instr/_pc4/_valid  IF/ID register contents
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | request outstanding at pc
// S_DRAIN | abandoned request still in flight at drain_addr; wait for ack
// S_HOLD  | fetched word parked in buf during a stall, no request
// ----------------------------------------------------------------------------
module if_fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [DATA_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    input  logic              stall,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [DATA_W-1:0] if_id_pc4,
    output logic              if_id_valid
);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] drain_addr_q, drain_addr_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_plus4;

    pc_adder u_pc_adder (
        .pc_in    (pc_q),
        .pc_plus4 (pc_plus4)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buf_d        = buf_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;

        if (branch_taken) begin
            // Redirect wins over stall; pc4 is left alone for bubbles.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            pc_d    = branch_target;
            case (state_q)
                S_FETCH: begin
                    if (!imem_ack) begin
                        // Request cannot be withdrawn: remember its address.
                        state_d      = S_DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) state_d = S_FETCH;
                end
                S_HOLD: begin
                    buf_d   = '0;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        if (stall) begin
                            buf_d   = imem_rdata;
                            state_d = S_HOLD;
                        end else begin
                            instr_d = imem_rdata;
                            pc4_d   = pc_plus4;
                            valid_d = 1'b1;
                            pc_d    = pc_plus4;
                        end
                    end else if (!stall) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) state_d = S_FETCH;
                    if (!stall) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instr_d = buf_q;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            buf_q        <= '0;
            instr_q      <= NOP_INSTR;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            buf_q        <= buf_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end

    // Reset gates the request immediately so no fetch is seen while held.
    assign imem_req    = !reset && (state_q != S_HOLD);
    assign imem_addr   = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign pc          = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

endmodule
